// File: rtl/display_pkg.sv
// Shared types and constants for the 7-segment scan controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, blank codes, and the active-low BCD segment table.
package display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        GUARD = 2'd2
    } state_t;

    // All segments off (active-low), and the BCD code that decodes to it.
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] BCD_BLANK = 4'hF;

    // Active-low pattern, bit order a[6] b[5] c[4] d[3] e[2] f[1] g[0].
    // Non-decimal codes render dark.
    function automatic logic [6:0] seg7_pattern(input logic [3:0] code);
        logic [6:0] pat;
        case (code)
            4'd0:    pat = 7'h01;
            4'd1:    pat = 7'h4F;
            4'd2:    pat = 7'h12;
            4'd3:    pat = 7'h06;
            4'd4:    pat = 7'h4C;
            4'd5:    pat = 7'h24;
            4'd6:    pat = 7'h20;
            4'd7:    pat = 7'h0F;
            4'd8:    pat = 7'h00;
            4'd9:    pat = 7'h04;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD to active-low 7-segment decoder; codes 10-15 render blank.
// Latency: combinational, zero cycles.
// Backpressure: none.
// Ports: code (4-bit BCD in), seg (7-bit active-low pattern out).
module seg7_decode
    import display_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    always_comb begin
        seg = seg7_pattern(code);
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for NUM_DIGITS common-anode digits with a double-buffered BCD word.
// Latency: all outputs registered; a host load is shown from the next frame boundary (same edge if coincident).
// Backpressure: none; load is a fire-and-forget strobe, the last load before a boundary wins.
// Ports: clk, rst_n (async active-low), enable, load, data_in[4*NUM_DIGITS] ->
//        digit_sel (active-low, one-hot-low), seg (active-low a..g), frame_done (pulse), update_pending.
// Build option: define LEADING_ZERO_BLANK_EN to darken leading zero digits (digit 0 always shown).
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic [6:0]              seg,
    output logic                    frame_done,
    output logic                    update_pending
);

    localparam int CNT_W  = $clog2(CLK_DIV);
    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam int DATA_W = 4 * NUM_DIGITS;

    // Terminal counts for the lit and dark parts of a slot.
    localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(CLK_DIV - BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [DATA_W-1:0] BUF_RESET = {NUM_DIGITS{BCD_BLANK}};

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_W-1:0]     shadow_q, shadow_d;
    logic [DATA_W-1:0]     active_q, active_d;
    logic                  pending_q, pending_d;
    logic [NUM_DIGITS-1:0] digit_sel_q, digit_sel_d;
    logic [6:0]            seg_q, seg_d;
    logic                  frame_done_q, frame_done_d;

    logic                  advance;
    logic                  boundary;
    logic [3:0]            cur_code;
    logic [6:0]            dec_seg;
    logic                  suppress;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            shadow_q     <= BUF_RESET;
            active_q     <= BUF_RESET;
            pending_q    <= 1'b0;
            digit_sel_q  <= '1;
            seg_q        <= SEG_BLANK;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
            digit_sel_q  <= digit_sel_d;
            seg_q        <= seg_d;
            frame_done_q <= frame_done_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic: slot timing, digit index, buffer commit
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        advance   = 1'b0;
        boundary  = 1'b0;

        if (load) begin
            shadow_d  = data_in;
            pending_d = 1'b1;
        end

        if (!enable) begin
            // Disable wins over everything in flight, including a boundary.
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = SCAN;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
                SCAN: begin
                    if (cnt_q == SCAN_LAST) begin
                        cnt_d = '0;
                        if (BLANK_CYCLES == 0) begin
                            advance = 1'b1;
                        end else begin
                            state_d = GUARD;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                GUARD: begin
                    if (cnt_q == GUARD_LAST) begin
                        cnt_d   = '0;
                        advance = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase

            if (advance) begin
                state_d = SCAN;
                if (idx_q == IDX_LAST) begin
                    idx_d    = '0;
                    boundary = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
        end

        // A load on the boundary edge bypasses the shadow so it is never lost.
        if (boundary) begin
            if (load) begin
                active_d  = data_in;
                pending_d = 1'b0;
            end else if (pending_q) begin
                active_d  = shadow_q;
                pending_d = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output logic. Decode from the next-state buffer and index so the
    // registered segments match the digit being enabled on the same edge,
    // including data committed on that very edge.
    // ------------------------------------------------------------------
    always_comb begin
        cur_code = BCD_BLANK;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_d == IDX_W'(i)) begin
                cur_code = active_d[4*i +: 4];
            end
        end
    end

    seg7_decode u_seg7_decode (
        .code (cur_code),
        .seg  (dec_seg)
    );

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] lz_mask;
    logic                  upper_zero;

    // lz_mask[k] = digit k and every digit above it are zero.
    always_comb begin
        upper_zero = 1'b1;
        lz_mask    = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            upper_zero = upper_zero & (active_d[4*i +: 4] == 4'd0);
            lz_mask[i] = upper_zero;
        end
        lz_mask[0] = 1'b0;
    end

    always_comb begin
        suppress = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_d == IDX_W'(i)) begin
                suppress = lz_mask[i];
            end
        end
    end
`else
    assign suppress = 1'b0;
`endif

    always_comb begin
        digit_sel_d  = '1;
        seg_d        = SEG_BLANK;
        frame_done_d = boundary;
        if (state_d == SCAN) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (idx_d == IDX_W'(i)) begin
                    digit_sel_d[i] = 1'b0;
                end
            end
            seg_d = suppress ? SEG_BLANK : dec_seg;
        end
    end

    assign digit_sel      = digit_sel_q;
    assign seg            = seg_q;
    assign frame_done     = frame_done_q;
    assign update_pending = pending_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl (4 digits, 8-cycle slots, 2 guard cycles).
// Latency: n/a.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_display_scan_ctrl;

    localparam int ND = 4;
    localparam int CD = 8;
    localparam int BC = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        load = 1'b0;
    logic [15:0] data_in = 16'h0000;
    logic [3:0]  digit_sel;
    logic [6:0]  seg;
    logic        frame_done;
    logic        update_pending;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    display_scan_ctrl #(
        .NUM_DIGITS   (ND),
        .CLK_DIV      (CD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .load           (load),
        .data_in        (data_in),
        .digit_sel      (digit_sel),
        .seg            (seg),
        .frame_done     (frame_done),
        .update_pending (update_pending)
    );

    typedef struct {
        logic [15:0]     data;
        logic            pre_vld;
        logic [15:0]     pre_data;
        logic [3:0][6:0] exp_seg;   // index = digit number
    } vec_t;

    typedef struct packed {
        logic [3:0] sel;
        logic [6:0] seg;
    } exp_t;

    vec_t vecs [5];
    exp_t sb [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Returns the number of edges until frame_done is seen (bounded).
    task automatic wait_frame(output int n);
        n = 0;
        while (n < 100) begin
            tick(1);
            n++;
            if (frame_done === 1'b1) break;
        end
        check("frame_done_seen", 32'(frame_done), 32'd1);
    endtask

    task automatic set_vec(input int k, input logic [15:0] d, input logic pv, input logic [15:0] pd,
                           input logic [6:0] e3, input logic [6:0] e2,
                           input logic [6:0] e1, input logic [6:0] e0);
        vecs[k].data       = d;
        vecs[k].pre_vld    = pv;
        vecs[k].pre_data   = pd;
        vecs[k].exp_seg[3] = e3;
        vecs[k].exp_seg[2] = e2;
        vecs[k].exp_seg[1] = e1;
        vecs[k].exp_seg[0] = e0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int         n;
        int         fd_cnt;
        logic [6:0] prev [4];
        logic [3:0] sel_tmp;
        exp_t       e;

        set_vec(0, 16'h1234, 1'b0, 16'h0000, 7'h4F, 7'h12, 7'h06, 7'h4C);
        set_vec(1, 16'h9090, 1'b1, 16'h5678, 7'h04, 7'h01, 7'h04, 7'h01);
`ifdef LEADING_ZERO_BLANK_EN
        set_vec(2, 16'h0042, 1'b0, 16'h0000, 7'h7F, 7'h7F, 7'h4C, 7'h12);
        set_vec(3, 16'hF0A9, 1'b0, 16'h0000, 7'h7F, 7'h01, 7'h7F, 7'h04);
        set_vec(4, 16'h0000, 1'b0, 16'h0000, 7'h7F, 7'h7F, 7'h7F, 7'h01);
`else
        set_vec(2, 16'h0042, 1'b0, 16'h0000, 7'h01, 7'h01, 7'h4C, 7'h12);
        set_vec(3, 16'hF0A9, 1'b0, 16'h0000, 7'h7F, 7'h01, 7'h7F, 7'h04);
        set_vec(4, 16'h0000, 1'b0, 16'h0000, 7'h01, 7'h01, 7'h01, 7'h01);
`endif
        for (int i = 0; i < 4; i++) prev[i] = 7'h7F;

        // Reset state
        tick(2);
        check("rst_digit_sel", 32'(digit_sel), 32'hF);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_pending", 32'(update_pending), 32'd0);
        rst_n = 1'b1;
        tick(1);
        check("idle_dark", 32'(digit_sel), 32'hF);

        // Scan walk with blank buffers
        enable = 1'b1;
        tick(1);
        check("walk0_sel", 32'(digit_sel), 32'hE);
        check("walk0_seg", 32'(seg), 32'h7F);
        tick(5);
        check("walk0_last_scan", 32'(digit_sel), 32'hE);
        tick(1);
        check("walk0_guard_sel", 32'(digit_sel), 32'hF);
        check("walk0_guard_seg", 32'(seg), 32'h7F);
        tick(2);
        check("walk1_sel", 32'(digit_sel), 32'hD);
        tick(8);
        check("walk2_sel", 32'(digit_sel), 32'hB);
        tick(8);
        check("walk3_sel", 32'(digit_sel), 32'h7);
        check("walk3_seg", 32'(seg), 32'h7F);
        check("walk_no_fd", 32'(frame_done), 32'd0);
        wait_frame(n);
        check("first_frame_len", 32'(n), 32'd8);
        check("wrap_sel", 32'(digit_sel), 32'hE);
        tick(1);
        check("fd_one_cycle", 32'(frame_done), 32'd0);
        wait_frame(n);
        check("frame_period", 32'(n), 32'd31);

        // Table-driven loads with scoreboard
        for (int k = 0; k < 5; k++) begin
            tick(1);
            if (vecs[k].pre_vld) begin
                load    = 1'b1;
                data_in = vecs[k].pre_data;
            end
            tick(1);
            load = 1'b0;
            tick(1);
            load    = 1'b1;
            data_in = vecs[k].data;
            tick(1);
            load = 1'b0;
            check("load_pending", 32'(update_pending), 32'd1);
            for (int i = 0; i < 4; i++) begin
                sel_tmp    = 4'b1111;
                sel_tmp[i] = 1'b0;
                e.sel      = sel_tmp;
                e.seg      = vecs[k].exp_seg[i];
                sb.push_back(e);
            end
            tick(4);
            check("old_data_sel", 32'(digit_sel), 32'hD);
            check("old_data_seg", 32'(seg), 32'(prev[1]));
            wait_frame(n);
            check("commit_timing", 32'(n), 32'd24);
            check("commit_pending", 32'(update_pending), 32'd0);
            for (int i = 0; i < 4; i++) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("slot_sel", 32'(digit_sel), 32'(e.sel));
                    check("slot_seg", 32'(seg), 32'(e.seg));
                end
                tick(6);
                check("slot_guard", 32'(digit_sel), 32'hF);
                if (i < 3) tick(2);
            end
            for (int i = 0; i < 4; i++) prev[i] = vecs[k].exp_seg[i];
            wait_frame(n);
            check("next_frame", 32'(n), 32'd2);
        end

        // Load coinciding with the frame-boundary edge
        tick(31);
        load    = 1'b1;
        data_in = 16'h0008;
        tick(1);
        load = 1'b0;
        check("bnd_fd", 32'(frame_done), 32'd1);
        check("bnd_pending", 32'(update_pending), 32'd0);
        check("bnd_sel", 32'(digit_sel), 32'hE);
        check("bnd_seg", 32'(seg), 32'h00);
        tick(8);
`ifdef LEADING_ZERO_BLANK_EN
        check("bnd_digit1", 32'(seg), 32'h7F);
`else
        check("bnd_digit1", 32'(seg), 32'h01);
`endif
        check("bnd_pending2", 32'(update_pending), 32'd0);

        // Enable dropped during digit 2 guard, then re-enabled
        tick(14);
        check("guard2_dark", 32'(digit_sel), 32'hF);
        enable = 1'b0;
        tick(1);
        check("dis_sel", 32'(digit_sel), 32'hF);
        check("dis_seg", 32'(seg), 32'h7F);
        fd_cnt = 0;
        repeat (40) begin
            tick(1);
            if (frame_done === 1'b1) fd_cnt++;
        end
        check("dis_no_fd", 32'(fd_cnt), 32'd0);
        check("dis_still_dark", 32'(digit_sel), 32'hF);
        enable = 1'b1;
        tick(1);
        check("reen_sel", 32'(digit_sel), 32'hE);
        check("reen_seg", 32'(seg), 32'h00);
        tick(5);
        check("reen_full_slot", 32'(digit_sel), 32'hE);
        tick(1);
        check("reen_guard", 32'(digit_sel), 32'hF);
        wait_frame(n);
        check("reen_frame", 32'(n), 32'd26);
        check("reen_buf_kept", 32'(seg), 32'h00);

        // Asynchronous reset mid-scan
        tick(2);
        load    = 1'b1;
        data_in = 16'h1111;
        tick(1);
        load = 1'b0;
        check("pre_rst_pending", 32'(update_pending), 32'd1);
        check("pre_rst_sel", 32'(digit_sel), 32'hE);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_sel", 32'(digit_sel), 32'hF);
        check("arst_seg", 32'(seg), 32'h7F);
        check("arst_pending", 32'(update_pending), 32'd0);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        check("post_rst_sel", 32'(digit_sel), 32'hE);
        check("post_rst_seg", 32'(seg), 32'h7F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
